mem_arbiter: RTL and testbench

- Single-port memory arbiter sitting directly downstream of the dcache and icache.
- Accepts word-granular read/write requests from the dcache and read requests from the icache.
- Serialises them onto one RAM port and returns data plus per-requestor wait signals.
- Dcache has priority; a starvation counter guarantees icache forward progress.

---
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for dcache (read/write) and icache (read).
// Dcache wins by default; a streak counter forces an icache grant after STARVE_LIMIT dcache wins.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [31:0]       iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [31:0]       dstore,
  output logic              dwait,
  output logic [31:0]       dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [31:0]       ramstore,
  input  logic [31:0]       ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {IDLE, DSERV, ISERV} state_t;

  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t     state_q, state_d;
  logic [3:0] dstreak_q, dstreak_d;
  logic       dreq;

  assign dreq = dREN | dWEN;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      dstreak_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      dstreak_q <= dstreak_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dstreak_d = dstreak_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    case (state_q)
      IDLE: begin
        if (dreq && iREN)  state_d = (dstreak_q == LIMIT) ? ISERV : DSERV;
        else if (dreq)     state_d = DSERV;
        else if (iREN)     state_d = ISERV;
      end
      DSERV: begin
        // Dropping both dcache strobes abandons the access without a wait pulse.
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == RAM_ACCESS) begin
            dwait   = 1'b0;
            state_d = IDLE;
            if (!dWEN) dload = ramload;
            if (iREN)  dstreak_d = (dstreak_q >= LIMIT) ? LIMIT : dstreak_q + 4'd1;
            else       dstreak_d = 4'd0;
          end
        end
      end
      ISERV: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RAM_ACCESS) begin
            iwait     = 1'b0;
            iload     = ramload;
            state_d   = IDLE;
            dstreak_d = 4'd0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, writes, starvation grant order, busy RAM, abort and mid-flight reset.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        iwait, dwait;
  logic [31:0] iload, dload;
  logic        ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;

  // RAM stand-in: auto mode answers ACCESS on any strobe with address-derived data.
  logic        auto;
  logic [1:0]  rs;
  logic [31:0] ramload_drv;
  assign ramstate = auto ? ((ramREN | ramWEN) ? 2'd2 : 2'd0) : rs;
  assign ramload  = auto ? (ramaddr ^ 32'hC0DE0000) : ramload_drv;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // Records completion order; bad counts load values that were wrong or leaked.
  task automatic collect(input int n, output string seq, output int bad);
    seq = "";
    bad = 0;
    for (int c = 0; c < 200 && seq.len() < n; c++) begin
      @(negedge CLK); #1;
      if (!dwait) begin
        seq = {seq, "D"};
        if (dload !== (daddr ^ 32'hC0DE0000)) bad++;
      end else if (dload !== 32'd0) bad++;
      if (!iwait) begin
        seq = {seq, "I"};
        if (iload !== (iaddr ^ 32'hC0DE0000)) bad++;
      end else if (iload !== 32'd0) bad++;
      if (!dwait && !iwait) bad++;
    end
  endtask

  task automatic test_reset;
    RST = 1'b1; auto = 1'b0; rs = 2'd2; ramload_drv = 32'hFFFFFFFF;
    iREN = 1'b1; dREN = 1'b1; dWEN = 1'b0; iaddr = 32'h4; daddr = 32'h8; dstore = 32'h55;
    repeat (2) @(posedge CLK);
    @(negedge CLK); #1;
    checks++; if ({iwait, dwait} !== 2'b11) begin errors++; $display("FAIL rst_waits got %b exp 11", {iwait, dwait}); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %b exp 00", {ramREN, ramWEN}); end
    checks++; if (ramaddr !== 32'd0 || ramstore !== 32'd0) begin errors++; $display("FAIL rst_ramaddr_store got %h/%h exp 0/0", ramaddr, ramstore); end
    checks++; if (iload !== 32'd0 || dload !== 32'd0) begin errors++; $display("FAIL rst_loads got %h/%h exp 0/0", iload, dload); end
    iREN = 1'b0; dREN = 1'b0; rs = 2'd0;
    RST = 1'b0;
  endtask

  task automatic test_dread;
    @(negedge CLK); dREN = 1'b1; daddr = 32'h40; ramload_drv = 32'hDEADBEEF; rs = 2'd0; #1;
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL rd_idle got ren=%b dwait=%b exp 0/1", ramREN, dwait); end
    @(negedge CLK); rs = 2'd1; #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL rd_issue got ren=%b addr=%h exp 1/40", ramREN, ramaddr); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 1'b1 || dload !== 32'd0) begin errors++; $display("FAIL rd_busy got dwait=%b dload=%h exp 1/0", dwait, dload); end
    @(negedge CLK); rs = 2'd2; #1;
    checks++; if (dwait !== 1'b0 || dload !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_done got dwait=%b dload=%h exp 0/deadbeef", dwait, dload); end
    checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL rd_iwait got %b exp 1", iwait); end
    @(negedge CLK); dREN = 1'b0; rs = 2'd0; #1;
    checks++; if (dwait !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL rd_after got dwait=%b ren=%b exp 1/0", dwait, ramREN); end
  endtask

  task automatic test_dwrite;
    @(negedge CLK); dWEN = 1'b1; daddr = 32'h3100; dstore = 32'h12; rs = 2'd0; #1;
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL wr_idle got wen=%b exp 0", ramWEN); end
    @(negedge CLK); rs = 2'd2; #1;
    checks++; if ({ramWEN, ramREN} !== 2'b10) begin errors++; $display("FAIL wr_strobes got %b exp 10", {ramWEN, ramREN}); end
    checks++; if (ramstore !== 32'h12 || ramaddr !== 32'h3100) begin errors++; $display("FAIL wr_data got %h@%h exp 12@3100", ramstore, ramaddr); end
    checks++; if (dwait !== 1'b0 || dload !== 32'd0) begin errors++; $display("FAIL wr_done got dwait=%b dload=%h exp 0/0", dwait, dload); end
    @(negedge CLK); dWEN = 1'b0; rs = 2'd0; #1;
    checks++; if (dwait !== 1'b1 || ramWEN !== 1'b0) begin errors++; $display("FAIL wr_after got dwait=%b wen=%b exp 1/0", dwait, ramWEN); end
  endtask

  task automatic test_starvation;
    string seq;
    int    bad;
    @(negedge CLK); daddr = 32'h100; iaddr = 32'h200; dREN = 1'b1; iREN = 1'b1; auto = 1'b1;
    collect(10, seq, bad);
    checks++; if (seq != "DDDDIDDDDI") begin errors++; $display("FAIL starve_order got %s exp DDDDIDDDDI", seq); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL starve_loads got %0d bad exp 0", bad); end
    @(negedge CLK); dREN = 1'b0; iREN = 1'b0; auto = 1'b0;
  endtask

  task automatic test_ibusy;
    @(negedge CLK); iREN = 1'b1; iaddr = 32'h8; rs = 2'd1; ramload_drv = 32'h600DF00D; #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL ib_idle got ren=%b iwait=%b exp 0/1", ramREN, iwait); end
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      checks++; if (iwait !== 1'b1 || ramREN !== 1'b1 || ramaddr !== 32'h8) begin
        errors++; $display("FAIL ib_busy%0d got iwait=%b ren=%b addr=%h exp 1/1/8", k, iwait, ramREN, ramaddr);
      end
    end
    @(negedge CLK); rs = 2'd2; #1;
    checks++; if (iwait !== 1'b0 || iload !== 32'h600DF00D || dwait !== 1'b1) begin
      errors++; $display("FAIL ib_done got iwait=%b iload=%h dwait=%b exp 0/600df00d/1", iwait, iload, dwait);
    end
    @(negedge CLK); rs = 2'd0; #1;
    checks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL ib_back_idle got ren=%b iwait=%b exp 0/1", ramREN, iwait); end
    iREN = 1'b0;
  endtask

  task automatic test_abort;
    string seq;
    int    bad;
    @(negedge CLK); daddr = 32'h100; iaddr = 32'h200; dREN = 1'b1; iREN = 1'b1; auto = 1'b1;
    collect(3, seq, bad);
    checks++; if (seq != "DDD" || bad !== 0) begin errors++; $display("FAIL ab_prime got %s bad=%0d exp DDD/0", seq, bad); end
    @(negedge CLK); auto = 1'b0; rs = 2'd1;
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin errors++; $display("FAIL ab_serving got ren=%b addr=%h exp 1/100", ramREN, ramaddr); end
    dREN = 1'b0; #1;
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1 || iwait !== 1'b1) begin
      errors++; $display("FAIL ab_drop got ren=%b dwait=%b iwait=%b exp 0/1/1", ramREN, dwait, iwait);
    end
    @(negedge CLK); dREN = 1'b1; rs = 2'd2; #1;
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL ab_idle got ren=%b dwait=%b exp 0/1", ramREN, dwait); end
    @(negedge CLK); #1;
    checks++; if (dwait !== 1'b0) begin errors++; $display("FAIL ab_4th_d got dwait=%b exp 0", dwait); end
    @(negedge CLK); #1;
    // Streak must still be 3 after the abort, so the 4th dcache win hands the next grant to icache.
    @(negedge CLK); #1;
    checks++; if (iwait !== 1'b0 || ramaddr !== 32'h200) begin errors++; $display("FAIL ab_streak_kept got iwait=%b addr=%h exp 0/200", iwait, ramaddr); end
    @(negedge CLK); dREN = 1'b0; iREN = 1'b0; rs = 2'd0;
  endtask

  task automatic test_reset_mid;
    string seq;
    int    bad;
    @(negedge CLK); daddr = 32'h100; iaddr = 32'h200; dREN = 1'b1; iREN = 1'b1; auto = 1'b1;
    collect(3, seq, bad);
    checks++; if (seq != "DDD" || bad !== 0) begin errors++; $display("FAIL rm_prime got %s bad=%0d exp DDD/0", seq, bad); end
    @(negedge CLK); auto = 1'b0; rs = 2'd1;
    @(negedge CLK); #1;
    checks++; if (ramREN !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rm_serving got ren=%b dwait=%b exp 1/1", ramREN, dwait); end
    RST = 1'b1; #1;
    checks++; if ({ramREN, ramWEN, dwait, iwait} !== 4'b0011 || ramaddr !== 32'd0 || dload !== 32'd0) begin
      errors++; $display("FAIL rm_outputs got strobes/waits=%b addr=%h dload=%h exp 0011/0/0", {ramREN, ramWEN, dwait, iwait}, ramaddr, dload);
    end
    @(negedge CLK); RST = 1'b0; auto = 1'b1;
    collect(5, seq, bad);
    checks++; if (seq != "DDDDI" || bad !== 0) begin errors++; $display("FAIL rm_streak_cleared got %s bad=%0d exp DDDDI/0", seq, bad); end
    @(negedge CLK); dREN = 1'b0; iREN = 1'b0; auto = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dread();
    test_dwrite();
    test_starvation();
    test_ibusy();
    test_abort();
    test_reset_mid();
    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
